// File: rtl/grant_dispatcher.sv
// grant_dispatcher: turns an encoded index into a held one-hot grant released by ack or timeout
module grant_dispatcher #(
  parameter int Count = 8,
  parameter int TimeoutCycles = 16,
  localparam int CountBits = $clog2(Count),
  localparam int TimerBits = TimeoutCycles < 1 ? 1 : $clog2(TimeoutCycles + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CountBits-1:0] select,
  input  logic                 select_valid,
  output logic                 select_ready,
  output logic [Count-1:0]     grant,
  input  logic [Count-1:0]     ack,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic                 error,
  output logic [CountBits-1:0] last_select
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic ready_n, busy_n, done_n, timeout_n, error_n, expired;
  logic [Count-1:0] grant_n;
  logic [CountBits-1:0] last_n;
  logic [TimerBits-1:0] timer, timer_n;
  assign expired = TimeoutCycles != 0 && timer == TimerBits'(TimeoutCycles - 1);
  // next state and registered outputs; ack beats timer expiry on the same edge
  always_comb begin
    state_n = state;
    ready_n = select_ready;
    grant_n = grant;
    busy_n = busy;
    done_n = 1'b0;
    timeout_n = 1'b0;
    error_n = 1'b0;
    last_n = last_select;
    timer_n = timer;
    if (state == IDLE) begin
      ready_n = 1'b1;
      if (select_valid && select_ready) begin
        if (int'(select) < Count) begin
          state_n = GRANT;
          ready_n = 1'b0;
          grant_n = Count'(1) << select;
          busy_n = 1'b1;
          last_n = select;
          timer_n = '0;
        end else error_n = 1'b1;
      end
    end else if (ack[last_select]) begin
      state_n = IDLE;
      ready_n = 1'b1;
      grant_n = '0;
      busy_n = 1'b0;
      done_n = 1'b1;
    end else if (expired) begin
      state_n = IDLE;
      ready_n = 1'b1;
      grant_n = '0;
      busy_n = 1'b0;
      timeout_n = 1'b1;
    end else if (timer != '1) timer_n = timer + TimerBits'(1);
  end
  // state and output registers; reset drops the grant immediately without any pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      select_ready <= 1'b0;
      grant <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      timeout <= 1'b0;
      error <= 1'b0;
      last_select <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      select_ready <= ready_n;
      grant <= grant_n;
      busy <= busy_n;
      done <= done_n;
      timeout <= timeout_n;
      error <= error_n;
      last_select <= last_n;
      timer <= timer_n;
    end
  end
endmodule

// File: tb/tb_grant_dispatcher.sv
// tb_grant_dispatcher: random and directed checks of grant_dispatcher against a transaction-level model
module tb_grant_dispatcher;
  localparam int C = 8;
  localparam int T = 16;
  logic clk = 0;
  logic reset = 0;
  logic [2:0] select = 0;
  logic select_valid = 0;
  logic select_ready, busy, done, timeout, error;
  logic [C-1:0] grant, ack = 0;
  logic [2:0] last_select;
  logic [2:0] sel6 = 0;
  logic v6 = 0;
  logic [5:0] ack6 = 0;
  logic [5:0] grant6;
  logic r6, busy6, done6, to6, err6;
  logic [2:0] last6;
  int tests = 0, fails = 0;
  bit started = 0;
  int m_owner, m_age;
  bit m_ready, m_done, m_to, m_err;
  logic [2:0] m_last;

  grant_dispatcher #(.Count(C), .TimeoutCycles(T)) dut (
    .clk(clk), .reset(reset), .select(select), .select_valid(select_valid),
    .select_ready(select_ready), .grant(grant), .ack(ack), .busy(busy), .done(done),
    .timeout(timeout), .error(error), .last_select(last_select));

  grant_dispatcher #(.Count(6), .TimeoutCycles(0)) dut6 (
    .clk(clk), .reset(reset), .select(sel6), .select_valid(v6),
    .select_ready(r6), .grant(grant6), .ack(ack6), .busy(busy6), .done(done6),
    .timeout(to6), .error(err6), .last_select(last6));

  always #5 clk = ~clk;

  // model: who owns the grant and for how many visible cycles it has been held
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = -1; m_age = 0; m_ready = 0; m_done = 0; m_to = 0; m_err = 0; m_last = 0;
    end else begin
      m_done = 0; m_to = 0; m_err = 0;
      if (m_owner < 0) begin
        if (select_valid && m_ready) begin
          if (int'(select) < C) begin
            m_owner = int'(select); m_last = select; m_age = 1; m_ready = 0;
          end else m_err = 1;
        end else m_ready = 1;
      end else if (ack[m_owner]) begin
        m_owner = -1; m_done = 1; m_ready = 1;
      end else if (T != 0 && m_age == T) begin
        m_owner = -1; m_to = 1; m_ready = 1;
      end else m_age++;
    end
  end

  // compare every cycle away from the active edge
  always @(negedge clk) begin
    logic [15:0] act, exp;
    if (started) begin
      act = {select_ready, grant, busy, done, timeout, error, last_select};
      exp = {m_ready, (m_owner < 0 ? 8'd0 : 8'(1 << m_owner)), m_owner >= 0, m_done, m_to, m_err, m_last};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL model t=%0t got rdy/grant/busy/done/to/err/last=%h expected %h", $time, act, exp);
      end
    end
  end

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input logic [2:0] s);
    for (int k = 0; k < 50 && !select_ready; k++) tick();
    check("ready_before_req", select_ready, 1);
    select = s; select_valid = 1;
    tick();
    select_valid = 0;
  endtask

  initial begin
    int g, to, dn;
    #1 reset = 1;
    started = 1;
    tick(); tick();
    check("reset_ready", select_ready, 0);
    check("reset_grant", grant, 0);
    #2 reset = 0;
    tick();
    check("ready_after_reset", select_ready, 1);
    // 1: ack two cycles after grant appears
    req(3);
    g = 0;
    g += int'(grant == 8'b0000_1000); tick();
    g += int'(grant == 8'b0000_1000); tick();
    g += int'(grant == 8'b0000_1000); ack = 8'b0000_1000; tick();
    ack = 0;
    check("t1_grant_cycles", g, 3);
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);
    check("t1_ready", select_ready, 1);
    tick();
    // 2: timeout after 16 visible cycles
    req(5);
    g = 0; to = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      g += int'(grant[5]); to += int'(timeout); dn += int'(done);
      tick();
    end
    check("t2_grant_cycles", g, 16);
    check("t2_timeouts", to, 1);
    check("t2_dones", dn, 0);
    // 4: foreign ack and select_valid ignored during GRANT
    req(2);
    ack = 8'b0001_0000; select = 1; select_valid = 1;
    tick(); tick(); tick();
    check("t4_grant_held", grant, 8'b0000_0100);
    check("t4_last", last_select, 2);
    ack = 8'b0000_0100;
    tick();
    ack = 0;
    check("t4_done", done, 1);
    check("t4_idle_gap", grant, 0);
    tick();
    select_valid = 0;
    check("t4_next_grant", grant, 8'b0000_0010);
    ack = 8'b0000_0010;
    tick();
    ack = 0;
    tick();
    // 5: ack on the expiry edge
    req(2);
    for (int i = 0; i < 15; i++) tick();
    ack = 8'b0000_0100;
    tick();
    ack = 0;
    check("t5_done", done, 1);
    check("t5_timeout", timeout, 0);
    tick();
    // 3 and no-timeout behaviour on a Count=6, TimeoutCycles=0 instance
    check("c6_ready", r6, 1);
    sel6 = 2; v6 = 1;
    tick();
    v6 = 0;
    g = 0; to = 0;
    for (int i = 0; i < 30; i++) begin
      g += int'(grant6 == 6'b000100); to += int'(to6);
      tick();
    end
    check("c6_grant_held", g, 30);
    check("c6_no_timeout", to, 0);
    ack6 = 6'b000100;
    tick();
    ack6 = 0;
    check("c6_done", done6, 1);
    sel6 = 7; v6 = 1;
    tick();
    v6 = 0;
    check("c6_error", err6, 1);
    check("c6_grant_zero", grant6, 0);
    check("c6_ready_kept", r6, 1);
    check("c6_last_kept", last6, 2);
    check("c6_busy", busy6, 0);
    tick();
    check("c6_error_pulse", err6, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      select_valid = ($urandom % 3) == 0;
      select = 3'($urandom);
      ack = ($urandom % 6 == 0) ? 8'(1 << ($urandom % 8)) : (($urandom % 8 == 0) ? 8'($urandom) : 8'd0);
      tick();
    end
    select_valid = 0; ack = 0;
    for (int k = 0; k < 40 && !select_ready; k++) tick();
    // 6: reset during a grant
    req(6);
    tick();
    check("t6_grant_before", grant, 8'b0100_0000);
    #2 reset = 1;
    #1;
    check("t6_grant_async", grant, 0);
    check("t6_busy_async", busy, 0);
    tick();
    check("t6_no_done", done, 0);
    check("t6_no_timeout", timeout, 0);
    check("t6_ready_in_reset", select_ready, 0);
    #2 reset = 0;
    tick();
    check("t6_ready_after", select_ready, 1);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
